// File: rtl/gpo_status_tx.sv
// gpo_status_tx
// Transmit side of the FPGA<->FX3 GPIO status link. A one-bit status update
// from the register file is driven onto GPO_status and announced to the FX3
// by holding Fpga_ready high for HOLD_CYCLES clocks, followed by a low gap of
// at least GAP_CYCLES clocks. One further update may be buffered while a
// notification is in flight; the newest buffered value wins.
//
// Handshake: valid is a one-cycle request with value_to_usb sampled on the
// same edge. There is no backpressure; busy is advisory only. A request that
// cannot be served (cable disconnected, or a buffered value overwritten) is
// reported by a one-cycle dropped pulse.
//
// Ports
//   clk, reset      system clock (40 MHz), asynchronous active-high reset
//   usb_connected   cable-connection flag from the connection detector
//   value_to_usb    status bit to transmit
//   valid           one-cycle request strobe
//   busy            combinational: notification in progress or entry pending
//   GPO_status      registered status pin to FX3
//   Fpga_ready      registered notification pin to FX3
//   done            one-cycle pulse when a notification completes
//   dropped         one-cycle pulse when a request is discarded
//   dbg_state       current FSM state (0 IDLE, 1 LOAD, 2 HOLD, 3 GAP)
module gpo_status_tx #(
  parameter int HOLD_CYCLES = 4000,
  parameter int GAP_CYCLES  = 400,
  parameter int CNT_W       = 12
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       usb_connected,
  input  logic       value_to_usb,
  input  logic       valid,
  output logic       busy,
  output logic       GPO_status,
  output logic       Fpga_ready,
  output logic       done,
  output logic       dropped,
  output logic [1:0] dbg_state
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_HOLD = 2'd2,
    S_GAP  = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(GAP_CYCLES - 1);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             gpo_q, gpo_d;
  logic             rdy_q, rdy_d;
  logic             done_q, done_d;
  logic             drop_q, drop_d;
  logic             pend_vld_q, pend_vld_d;
  logic             pend_val_q, pend_val_d;
  logic             store_req;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    gpo_d      = gpo_q;
    rdy_d      = rdy_q;
    done_d     = 1'b0;
    drop_d     = 1'b0;
    pend_vld_d = pend_vld_q;
    pend_val_d = pend_val_q;
    store_req  = 1'b0;

    if (state_q == S_IDLE) begin
      if (valid) begin
        if (usb_connected) begin
          gpo_d   = value_to_usb;
          state_d = S_LOAD;
        end else begin
          drop_d = 1'b1;
        end
      end
    end else if (!usb_connected) begin
      // Disconnect wins over everything else. One dropped pulse covers an
      // aborted notification, a discarded pending entry and a same-cycle
      // request alike.
      state_d    = S_IDLE;
      rdy_d      = 1'b0;
      cnt_d      = '0;
      pend_vld_d = 1'b0;
      drop_d     = (state_q != S_GAP) | pend_vld_q | valid;
    end else begin
      unique case (state_q)
        S_LOAD: begin
          rdy_d     = 1'b1;
          cnt_d     = '0;
          state_d   = S_HOLD;
          store_req = valid;
        end
        S_HOLD: begin
          store_req = valid;
          if (cnt_q == HOLD_LAST) begin
            rdy_d   = 1'b0;
            done_d  = 1'b1;
            cnt_d   = '0;
            state_d = S_GAP;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        S_GAP: begin
          if (cnt_q == GAP_LAST) begin
            // A fresh request in the last gap cycle goes straight out and
            // supersedes anything that was buffered.
            cnt_d = '0;
            if (valid) begin
              gpo_d      = value_to_usb;
              pend_vld_d = 1'b0;
              drop_d     = pend_vld_q;
              state_d    = S_LOAD;
            end else if (pend_vld_q) begin
              gpo_d      = pend_val_q;
              pend_vld_d = 1'b0;
              state_d    = S_LOAD;
            end else begin
              state_d = S_IDLE;
            end
          end else begin
            cnt_d     = cnt_q + CNT_W'(1);
            store_req = valid;
          end
        end
        default: begin
          state_d = S_IDLE;
        end
      endcase

      if (store_req) begin
        pend_vld_d = 1'b1;
        pend_val_d = value_to_usb;
        drop_d     = pend_vld_q;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      gpo_q      <= 1'b0;
      rdy_q      <= 1'b0;
      done_q     <= 1'b0;
      drop_q     <= 1'b0;
      pend_vld_q <= 1'b0;
      pend_val_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      gpo_q      <= gpo_d;
      rdy_q      <= rdy_d;
      done_q     <= done_d;
      drop_q     <= drop_d;
      pend_vld_q <= pend_vld_d;
      pend_val_q <= pend_val_d;
    end
  end

  assign busy       = (state_q != S_IDLE) | pend_vld_q;
  assign GPO_status = gpo_q;
  assign Fpga_ready = rdy_q;
  assign done       = done_q;
  assign dropped    = drop_q;
  assign dbg_state  = state_q;

endmodule

// File: tb/tb_gpo_status_tx.sv
// Bench for gpo_status_tx. A small instance (HOLD=8, GAP=4) is checked every
// cycle against a reference model that tracks only "cycles since the
// notification was loaded" plus a pending-value queue; a default-sized
// instance is used for the full-length hold measurement and the async reset.
module tb_gpo_status_tx;

  localparam int HS = 8;
  localparam int GS = 4;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_s = 1'b1, usb_s = 1'b0, val_s = 1'b0, v_s = 1'b0;
  logic       busy_s, gpo_s, rdy_s, done_s, drop_s;
  logic [1:0] dbg_s;

  logic       rst_d = 1'b1, usb_d = 1'b0, val_d = 1'b0, v_d = 1'b0;
  logic       busy_d, gpo_d, rdy_d, done_d, drop_d;
  logic [1:0] dbg_d;

  gpo_status_tx #(.HOLD_CYCLES(HS), .GAP_CYCLES(GS), .CNT_W(4)) dut_s (
    .clk(clk), .reset(rst_s), .usb_connected(usb_s), .value_to_usb(val_s),
    .valid(v_s), .busy(busy_s), .GPO_status(gpo_s), .Fpga_ready(rdy_s),
    .done(done_s), .dropped(drop_s), .dbg_state(dbg_s)
  );

  gpo_status_tx dut_d (
    .clk(clk), .reset(rst_d), .usb_connected(usb_d), .value_to_usb(val_d),
    .valid(v_d), .busy(busy_d), .GPO_status(gpo_d), .Fpga_ready(rdy_d),
    .done(done_d), .dropped(drop_d), .dbg_state(dbg_d)
  );

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_checks++;
    assert (obs === exp_v) n_pass++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp_v);
  endtask

  // ---------------- reference model ----------------
  // m_t counts clocks since the notification was loaded:
  // 0 = setup, 1..HS = ready high, HS+1..HS+GS = gap.
  bit   m_active;
  int   m_t;
  logic m_gpo;
  bit   m_done, m_drop;
  logic pend_q[$];

  int obs_rdy, obs_done, obs_drop;

  task automatic model_reset();
    m_active = 0; m_t = 0; m_gpo = 1'b0; m_done = 0; m_drop = 0;
    pend_q.delete();
    obs_rdy = 0; obs_done = 0; obs_drop = 0;
  endtask

  task automatic model_edge(input logic v, input logic val, input logic usb);
    m_done = 0;
    m_drop = 0;
    if (!m_active) begin
      if (v) begin
        if (usb) begin
          m_gpo = val; m_active = 1; m_t = 0;
        end else begin
          m_drop = 1;
        end
      end
    end else if (!usb) begin
      m_drop   = (m_t <= HS) || (pend_q.size() != 0) || v;
      m_active = 0;
      m_t      = 0;
      pend_q.delete();
    end else if (m_t == HS + GS) begin
      if (v) begin
        m_drop = (pend_q.size() != 0);
        pend_q.delete();
        m_gpo = val; m_t = 0;
      end else if (pend_q.size() != 0) begin
        m_gpo = pend_q.pop_front(); m_t = 0;
      end else begin
        m_active = 0;
      end
    end else begin
      if (v) begin
        if (pend_q.size() != 0) begin
          m_drop = 1;
          pend_q.delete();
        end
        pend_q.push_back(val);
      end
      m_t++;
      if (m_t == HS + 1) m_done = 1;
    end
  endtask

  task automatic check_small(input string tag);
    chk({tag, ".gpo"},  {31'd0, gpo_s},  {31'd0, m_gpo});
    chk({tag, ".rdy"},  {31'd0, rdy_s},  {31'd0, (m_active && m_t >= 1 && m_t <= HS)});
    chk({tag, ".done"}, {31'd0, done_s}, {31'd0, m_done});
    chk({tag, ".drop"}, {31'd0, drop_s}, {31'd0, m_drop});
    chk({tag, ".busy"}, {31'd0, busy_s}, {31'd0, (m_active || pend_q.size() != 0)});
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick_s(input string tag, input logic v, input logic val, input logic usb);
    v_s = v; val_s = val; usb_s = usb;
    @(posedge clk);
    model_edge(v, val, usb);
    #1;
    check_small(tag);
    if (rdy_s === 1'b1)  obs_rdy++;
    if (done_s === 1'b1) obs_done++;
    if (drop_s === 1'b1) obs_drop++;
    v_s = 1'b0;
  endtask

  task automatic reset_s();
    rst_s = 1'b1; v_s = 1'b0; usb_s = 1'b1;
    #2;
    model_reset();
    check_small("reset");
    @(posedge clk);
    #1;
    rst_s = 1'b0;
  endtask

  int hi_cnt, dn_cnt;

  // ---------------- directed + random sequence ----------------
  initial begin
    // T1: single notification
    reset_s();
    tick_s("t1", 1'b1, 1'b1, 1'b1);
    chk("t1.gpo_after_e1", {31'd0, gpo_s}, 32'd1);
    for (int i = 0; i < 15; i++) tick_s("t1", 1'b0, 1'b0, 1'b1);
    chk("t1.rdy_cycles", obs_rdy, HS);
    chk("t1.done_count", obs_done, 1);
    chk("t1.drop_count", obs_drop, 0);

    // T2: pending overwrite, second notification from buffer
    reset_s();
    tick_s("t2", 1'b1, 1'b1, 1'b1);
    for (int i = 0; i < 3; i++) tick_s("t2", 1'b0, 1'b0, 1'b1);
    tick_s("t2", 1'b1, 1'b0, 1'b1);
    tick_s("t2", 1'b1, 1'b1, 1'b1);
    chk("t2.drop_e6", {31'd0, drop_s}, 32'd1);
    for (int i = 0; i < 8; i++) tick_s("t2", 1'b0, 1'b0, 1'b1);
    chk("t2.load_e14_rdy", {31'd0, rdy_s}, 32'd0);
    chk("t2.load_e14_gpo", {31'd0, gpo_s}, 32'd1);
    chk("t2.load_e14_busy", {31'd0, busy_s}, 32'd1);
    for (int i = 0; i < 16; i++) tick_s("t2", 1'b0, 1'b0, 1'b1);
    chk("t2.done_count", obs_done, 2);
    chk("t2.drop_count", obs_drop, 1);
    chk("t2.rdy_cycles", obs_rdy, 2 * HS);

    // T3: disconnect mid-HOLD with a pending entry
    reset_s();
    tick_s("t3", 1'b1, 1'b1, 1'b1);
    tick_s("t3", 1'b0, 1'b0, 1'b1);
    tick_s("t3", 1'b0, 1'b0, 1'b1);
    tick_s("t3", 1'b1, 1'b0, 1'b1);
    tick_s("t3", 1'b0, 1'b0, 1'b1);
    tick_s("t3", 1'b0, 1'b0, 1'b0);
    chk("t3.rdy_e6", {31'd0, rdy_s}, 32'd0);
    chk("t3.busy_e6", {31'd0, busy_s}, 32'd0);
    chk("t3.drop_e6", {31'd0, drop_s}, 32'd1);
    chk("t3.gpo_e6", {31'd0, gpo_s}, 32'd1);
    for (int i = 0; i < 4; i++) tick_s("t3", 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) tick_s("t3", 1'b0, 1'b0, 1'b1);
    chk("t3.done_count", obs_done, 0);
    chk("t3.drop_count", obs_drop, 1);

    // T4: requests while disconnected
    reset_s();
    tick_s("t4", 1'b1, 1'b1, 1'b0);
    chk("t4.drop", {31'd0, drop_s}, 32'd1);
    chk("t4.gpo", {31'd0, gpo_s}, 32'd0);
    for (int i = 0; i < 10; i++) tick_s("t4", 1'b0, 1'b0, 1'b0);
    tick_s("t4", 1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) tick_s("t4", 1'b0, 1'b0, 1'b0);
    chk("t4.rdy_cycles", obs_rdy, 0);
    chk("t4.drop_count", obs_drop, 2);

    // T5: request lands in the final GAP cycle with nothing pending
    reset_s();
    tick_s("t5", 1'b1, 1'b1, 1'b1);
    for (int i = 0; i < 12; i++) tick_s("t5", 1'b0, 1'b0, 1'b1);
    tick_s("t5", 1'b1, 1'b0, 1'b1);
    chk("t5.gpo_e14", {31'd0, gpo_s}, 32'd0);
    chk("t5.drop_e14", {31'd0, drop_s}, 32'd0);
    chk("t5.rdy_e14", {31'd0, rdy_s}, 32'd0);
    chk("t5.busy_e14", {31'd0, busy_s}, 32'd1);
    for (int i = 0; i < 14; i++) tick_s("t5", 1'b0, 1'b0, 1'b1);
    chk("t5.done_count", obs_done, 2);
    chk("t5.drop_count", obs_drop, 0);

    // T6: randomized traffic with brief disconnects
    reset_s();
    for (int i = 0; i < 2000; i++)
      tick_s("rnd", ($urandom_range(0, 5) == 0), 1'($urandom_range(0, 1)),
             ($urandom_range(0, 39) != 0));

    // T7: default-sized instance, full-length hold then async reset mid-HOLD
    rst_s = 1'b1;
    #2;
    chk("d.reset_rdy", {31'd0, rdy_d}, 32'd0);
    chk("d.reset_gpo", {31'd0, gpo_d}, 32'd0);
    @(negedge clk);
    rst_d = 1'b0; usb_d = 1'b1;
    v_d = 1'b1; val_d = 1'b1;
    @(posedge clk);
    #1;
    v_d = 1'b0;
    hi_cnt = 0; dn_cnt = 0;
    for (int i = 0; i < 4500; i++) begin
      @(posedge clk);
      #1;
      if (rdy_d === 1'b1)  hi_cnt++;
      if (done_d === 1'b1) dn_cnt++;
    end
    chk("d.rdy_cycles", hi_cnt, 4000);
    chk("d.done_count", dn_cnt, 1);
    chk("d.gpo", {31'd0, gpo_d}, 32'd1);
    chk("d.idle_busy", {31'd0, busy_d}, 32'd0);

    v_d = 1'b1; val_d = 1'b0;
    @(posedge clk);
    #1;
    v_d = 1'b0;
    for (int i = 0; i < 2001; i++) @(posedge clk);
    #4;
    chk("d.rdy_mid_hold", {31'd0, rdy_d}, 32'd1);
    chk("d.gpo_mid_hold", {31'd0, gpo_d}, 32'd0);
    rst_d = 1'b1;
    #1;
    chk("d.async_rdy", {31'd0, rdy_d}, 32'd0);
    chk("d.async_busy", {31'd0, busy_d}, 32'd0);
    chk("d.async_done", {31'd0, done_d}, 32'd0);
    chk("d.async_drop", {31'd0, drop_d}, 32'd0);
    chk("d.async_gpo", {31'd0, gpo_d}, 32'd0);
    @(posedge clk);
    #1;
    chk("d.no_done_after_reset", {31'd0, done_d}, 32'd0);
    rst_d = 1'b0;

    // ---------------- final report ----------------
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
